// File: rtl/dmem_access_unit_pkg.sv
// Package dmem_au_pkg: shared constants, state type and helpers for the
// dmem_access_unit load/store unit.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned-access trapping).
package dmem_au_pkg;

  localparam logic [1:0] MEM_OP_READ  = 2'd0;
  localparam logic [1:0] MEM_OP_WRITE = 2'd1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } au_state_t;

  // The illegal size encoding 3 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

  // A half must sit on an even byte, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Bus interfaces of dmem_access_unit: the CPU MEM-stage side and the
// data-memory port side, each with master/slave modports.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (affects only io_resp_exc).

// CPU side: the MEM stage is the master, the access unit the slave.
interface dmem_au_cpu_if #(parameter int ADDR_W = 32);
  logic              io_req_valid;
  logic              io_req_ready;
  logic              io_req_write;
  logic [1:0]        io_req_size;
  logic              io_req_signed;
  logic [ADDR_W-1:0] io_req_addr;
  logic [31:0]       io_req_wdata;
  logic              io_resp_valid;
  logic [31:0]       io_resp_rdata;
  logic              io_resp_exc;

  modport master (
    output io_req_valid, io_req_write, io_req_size, io_req_signed,
           io_req_addr, io_req_wdata,
    input  io_req_ready, io_resp_valid, io_resp_rdata, io_resp_exc
  );

  modport slave (
    input  io_req_valid, io_req_write, io_req_size, io_req_signed,
           io_req_addr, io_req_wdata,
    output io_req_ready, io_resp_valid, io_resp_rdata, io_resp_exc
  );
endinterface

// Memory side: the access unit is the master, the data memory the slave.
interface dmem_au_mem_if;
  logic        io_dmem_request_valid;
  logic [31:0] io_dmem_request_bits_address;
  logic [31:0] io_dmem_request_bits_writedata;
  logic [1:0]  io_dmem_request_bits_operation;
  logic        io_dmem_response_valid;
  logic [31:0] io_dmem_response_bits_data;

  modport master (
    output io_dmem_request_valid, io_dmem_request_bits_address,
           io_dmem_request_bits_writedata, io_dmem_request_bits_operation,
    input  io_dmem_response_valid, io_dmem_response_bits_data
  );

  modport slave (
    input  io_dmem_request_valid, io_dmem_request_bits_address,
           io_dmem_request_bits_writedata, io_dmem_request_bits_operation,
    output io_dmem_response_valid, io_dmem_response_bits_data
  );
endinterface

// File: rtl/dmem_access_unit_lane.sv
// dmem_lane_unit: combinational byte/half lane logic. Extracts and extends
// load data from a memory word, and merges sub-word store data into it.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (not used here).
module dmem_lane_unit
  import dmem_au_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_lane = (BIG_ENDIAN != 1'b0) ? (2'd3 - addr_lo) : addr_lo;
  assign half_lane = (BIG_ENDIAN != 1'b0) ? ~addr_lo[1] : addr_lo[1];
  assign sel_byte  = rd_word[{byte_lane, 3'b000} +: 8];
  assign sel_half  = rd_word[{half_lane, 4'b0000} +: 16];

  // Pick the addressed lane for loads and overwrite only that lane for stores.
  always_comb begin
    load_data   = rd_word;
    merged_data = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data   = {{24{is_signed & sel_byte[7]}}, sel_byte};
        merged_data = rd_word;
        merged_data[{byte_lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data   = {{16{is_signed & sel_half[15]}}, sel_half};
        merged_data = rd_word;
        merged_data[{half_lane, 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data   = rd_word;
        merged_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store unit between the MEM stage and a data-memory
// port without byte enables. Sub-word stores run as read-modify-write.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, misaligned
// accesses are trapped (io_resp_exc=1, no memory traffic); otherwise the
// low address bits below the access size are simply ignored.
module dmem_access_unit
  import dmem_au_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic           clock,
  input logic           reset,
  dmem_au_cpu_if.slave  cpu,
  dmem_au_mem_if.master dmem
);

  au_state_t         state;
  au_state_t         next_state;

  logic              req_write;
  logic              req_signed;
  logic              req_exc;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       mem_word;

  logic [1:0]        in_size;
  logic              in_misaligned;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       load_data;
  logic [31:0]       merged_data;

  assign in_size = norm_size(cpu.io_req_size);

`ifdef DMEM_ALIGN_CHECK_EN
  assign in_misaligned = is_misaligned(in_size, cpu.io_req_addr[1:0]);
`else
  assign in_misaligned = 1'b0;
`endif

  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  dmem_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .rd_word     (mem_word),
    .addr_lo     (req_addr[1:0]),
    .size        (req_size),
    .is_signed   (req_signed),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  // State register, request latch on acceptance, read-word capture in READ.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_write  <= 1'b0;
      req_signed <= 1'b0;
      req_exc    <= 1'b0;
      req_size   <= SIZE_BYTE;
      req_addr   <= '0;
      req_wdata  <= '0;
      mem_word   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cpu.io_req_valid) begin
        req_write  <= cpu.io_req_write;
        req_signed <= cpu.io_req_signed;
        req_exc    <= in_misaligned;
        req_size   <= in_size;
        req_addr   <= cpu.io_req_addr;
        req_wdata  <= cpu.io_req_wdata;
      end
      if (state == READ && dmem.io_dmem_response_valid) begin
        mem_word <= dmem.io_dmem_response_bits_data;
      end
    end
  end

  // Next-state logic and all bus outputs; everything idles at zero.
  always_comb begin
    next_state                          = state;
    cpu.io_req_ready                    = 1'b0;
    cpu.io_resp_valid                   = 1'b0;
    cpu.io_resp_rdata                   = 32'h0;
    cpu.io_resp_exc                     = 1'b0;
    dmem.io_dmem_request_valid          = 1'b0;
    dmem.io_dmem_request_bits_address   = 32'h0;
    dmem.io_dmem_request_bits_writedata = 32'h0;
    dmem.io_dmem_request_bits_operation = MEM_OP_READ;
    case (state)
      IDLE: begin
        cpu.io_req_ready = 1'b1;
        if (cpu.io_req_valid) begin
          if (in_misaligned) begin
            next_state = RESP;
          end else if (cpu.io_req_write && in_size == SIZE_WORD) begin
            next_state = WRITE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ: begin
        dmem.io_dmem_request_valid          = 1'b1;
        dmem.io_dmem_request_bits_address   = 32'(word_addr);
        dmem.io_dmem_request_bits_operation = MEM_OP_READ;
        if (dmem.io_dmem_response_valid) begin
          next_state = req_write ? WRITE : RESP;
        end
      end
      WRITE: begin
        dmem.io_dmem_request_valid          = 1'b1;
        dmem.io_dmem_request_bits_address   = 32'(word_addr);
        dmem.io_dmem_request_bits_writedata = merged_data;
        dmem.io_dmem_request_bits_operation = MEM_OP_WRITE;
        if (dmem.io_dmem_response_valid) begin
          next_state = RESP;
        end
      end
      RESP: begin
        cpu.io_resp_valid = 1'b1;
        cpu.io_resp_rdata = (req_write || req_exc) ? 32'h0 : load_data;
        cpu.io_resp_exc   = req_exc;
        next_state        = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench for dmem_access_unit. A little-endian
// instance talks to a stallable word memory; a big-endian instance talks to a
// fixed zero-wait word. Expected responses are queued at issue time and a
// monitor per instance compares them when io_resp_valid appears.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (changes expected misaligned results).
module tb_dmem_access_unit;
  import dmem_au_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    int          resp_edge;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int total_checks = 0;
  int bad_checks   = 0;
  int edge_count   = 0;

  exp_t le_q[$];
  exp_t be_q[$];
  exp_t le_e;
  exp_t be_e;

  // Little-endian memory model state.
  logic [31:0] mem [0:255] = '{64: 32'h8899AABB, default: 32'h0};
  int stall_cycles = 0;
  int stall_cnt    = 0;
  int read_ops     = 0;
  int write_ops    = 0;
  int req_cycles   = 0;

  dmem_au_cpu_if #(.ADDR_W(32)) cpu_bus ();
  dmem_au_mem_if                mem_bus ();
  dmem_au_cpu_if #(.ADDR_W(32)) be_cpu_bus ();
  dmem_au_mem_if                be_mem_bus ();

  dmem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clock (clock),
    .reset (reset),
    .cpu   (cpu_bus),
    .dmem  (mem_bus)
  );

  dmem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clock (clock),
    .reset (reset),
    .cpu   (be_cpu_bus),
    .dmem  (be_mem_bus)
  );

  always #5 clock = ~clock;

  // Counts rising edges so the scoreboard can check response timing.
  always @(posedge clock) edge_count <= edge_count + 1;

  // Little-endian memory: answers after stall_cycles waiting cycles, same cycle when zero.
  assign mem_bus.io_dmem_response_valid =
    mem_bus.io_dmem_request_valid && (stall_cnt >= stall_cycles);
  assign mem_bus.io_dmem_response_bits_data =
    mem_bus.io_dmem_request_valid ? mem[mem_bus.io_dmem_request_bits_address[9:2]] : 32'h0;

  // Memory write port, stall counter and transaction counters.
  always @(posedge clock) begin
    if (mem_bus.io_dmem_request_valid) req_cycles <= req_cycles + 1;
    if (reset || !mem_bus.io_dmem_request_valid || mem_bus.io_dmem_response_valid)
      stall_cnt <= 0;
    else
      stall_cnt <= stall_cnt + 1;
    if (mem_bus.io_dmem_request_valid && mem_bus.io_dmem_response_valid) begin
      if (mem_bus.io_dmem_request_bits_operation == MEM_OP_WRITE) begin
        mem[mem_bus.io_dmem_request_bits_address[9:2]] <= mem_bus.io_dmem_request_bits_writedata;
        write_ops <= write_ops + 1;
      end else begin
        read_ops <= read_ops + 1;
      end
    end
  end

  // Big-endian memory: a single fixed word, zero wait.
  assign be_mem_bus.io_dmem_response_valid     = be_mem_bus.io_dmem_request_valid;
  assign be_mem_bus.io_dmem_response_bits_data = 32'h8899AABB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Little-endian response monitor.
  always @(negedge clock) begin
    if (cpu_bus.io_resp_valid) begin
      if (le_q.size() == 0) begin
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL le_unexpected_resp: got resp_valid=1, want 0 (t=%0t)", $time);
      end else begin
        le_e = le_q.pop_front();
        checkOutput("le_rdata", cpu_bus.io_resp_rdata, le_e.rdata);
        checkOutput("le_exc", {31'b0, cpu_bus.io_resp_exc}, {31'b0, le_e.exc});
        checkOutput("le_resp_edge", edge_count, le_e.resp_edge);
      end
    end
  end

  // Big-endian response monitor.
  always @(negedge clock) begin
    if (be_cpu_bus.io_resp_valid) begin
      if (be_q.size() == 0) begin
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL be_unexpected_resp: got resp_valid=1, want 0 (t=%0t)", $time);
      end else begin
        be_e = be_q.pop_front();
        checkOutput("be_rdata", be_cpu_bus.io_resp_rdata, be_e.rdata);
        checkOutput("be_exc", {31'b0, be_cpu_bus.io_resp_exc}, {31'b0, be_e.exc});
        checkOutput("be_resp_edge", edge_count, be_e.resp_edge);
      end
    end
  end

  // Issues one request; lat is the number of edges after acceptance edge N
  // at which the response is expected (0 = seen just after edge N).
  task automatic applyStimulus(input bit use_be, input bit wr, input logic [1:0] size,
                               input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input bit exp_exc, input int lat,
                               input bit push, output int accept_edge);
    bit   rdy;
    exp_t e;
    rdy = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clock);
      rdy = use_be ? be_cpu_bus.io_req_ready : cpu_bus.io_req_ready;
    end
    if (!rdy) begin
      total_checks++;
      bad_checks++;
      $display("[TB] FAIL ready_timeout: got ready=0, want 1 (t=%0t)", $time);
    end
    if (use_be) begin
      be_cpu_bus.io_req_valid  = 1'b1;
      be_cpu_bus.io_req_write  = wr;
      be_cpu_bus.io_req_size   = size;
      be_cpu_bus.io_req_signed = sgn;
      be_cpu_bus.io_req_addr   = addr;
      be_cpu_bus.io_req_wdata  = wdata;
    end else begin
      cpu_bus.io_req_valid  = 1'b1;
      cpu_bus.io_req_write  = wr;
      cpu_bus.io_req_size   = size;
      cpu_bus.io_req_signed = sgn;
      cpu_bus.io_req_addr   = addr;
      cpu_bus.io_req_wdata  = wdata;
    end
    accept_edge = edge_count + 1;
    if (push) begin
      e.rdata     = exp_rdata;
      e.exc       = exp_exc;
      e.resp_edge = accept_edge + lat;
      if (use_be) be_q.push_back(e);
      else        le_q.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    if (use_be) be_cpu_bus.io_req_valid = 1'b0;
    else        cpu_bus.io_req_valid    = 1'b0;
  endtask

  task automatic waitIdle(input bit use_be);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clock);
      done = use_be ? (be_q.size() == 0 && be_cpu_bus.io_req_ready)
                    : (le_q.size() == 0 && cpu_bus.io_req_ready);
    end
    if (!done) begin
      total_checks++;
      bad_checks++;
      $display("[TB] FAIL resp_timeout: got no response, want one (t=%0t)", $time);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int r0, w0, q0;

    cpu_bus.io_req_valid     = 1'b0;
    cpu_bus.io_req_write     = 1'b0;
    cpu_bus.io_req_size      = 2'd0;
    cpu_bus.io_req_signed    = 1'b0;
    cpu_bus.io_req_addr      = 32'h0;
    cpu_bus.io_req_wdata     = 32'h0;
    be_cpu_bus.io_req_valid  = 1'b0;
    be_cpu_bus.io_req_write  = 1'b0;
    be_cpu_bus.io_req_size   = 2'd0;
    be_cpu_bus.io_req_signed = 1'b0;
    be_cpu_bus.io_req_addr   = 32'h0;
    be_cpu_bus.io_req_wdata  = 32'h0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state.
    checkOutput("rst_ready", {31'b0, cpu_bus.io_req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, cpu_bus.io_resp_valid}, 32'd0);
    checkOutput("rst_rdata", cpu_bus.io_resp_rdata, 32'h0);
    checkOutput("rst_exc", {31'b0, cpu_bus.io_resp_exc}, 32'd0);
    checkOutput("rst_req_valid", {31'b0, mem_bus.io_dmem_request_valid}, 32'd0);
    checkOutput("rst_address", mem_bus.io_dmem_request_bits_address, 32'h0);
    checkOutput("rst_writedata", mem_bus.io_dmem_request_bits_writedata, 32'h0);
    checkOutput("rst_operation", {30'b0, mem_bus.io_dmem_request_bits_operation}, 32'd0);
    checkOutput("rst_be_ready", {31'b0, be_cpu_bus.io_req_ready}, 32'd1);

    // Byte loads, little-endian: word 0x100 = 0x8899AABB.
    applyStimulus(0, 0, SIZE_BYTE, 1, 32'h101, 32'h0, 32'hFFFFFFAA, 0, 1, 1, n);
    waitIdle(0);
    applyStimulus(0, 0, SIZE_BYTE, 0, 32'h101, 32'h0, 32'h000000AA, 0, 1, 1, n);
    waitIdle(0);

    // Half loads: little-endian upper half, big-endian lower half.
    applyStimulus(0, 0, SIZE_HALF, 1, 32'h102, 32'h0, 32'hFFFF8899, 0, 1, 1, n);
    waitIdle(0);
    applyStimulus(1, 0, SIZE_HALF, 1, 32'h102, 32'h0, 32'hFFFFAABB, 0, 1, 1, n);
    waitIdle(1);
    applyStimulus(1, 0, SIZE_BYTE, 1, 32'h100, 32'h0, 32'hFFFFFF88, 0, 1, 1, n);
    waitIdle(1);

    // Misaligned word and half loads.
    r0 = read_ops;
    q0 = req_cycles;
`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus(0, 0, SIZE_WORD, 0, 32'h102, 32'h0, 32'h0, 1, 0, 1, n);
    waitIdle(0);
    applyStimulus(0, 0, SIZE_HALF, 1, 32'h101, 32'h0, 32'h0, 1, 0, 1, n);
    waitIdle(0);
    checkOutput("mis_no_dmem_req", req_cycles - q0, 32'd0);
`else
    applyStimulus(0, 0, SIZE_WORD, 0, 32'h102, 32'h0, 32'h8899AABB, 0, 1, 1, n);
    waitIdle(0);
    applyStimulus(0, 0, SIZE_HALF, 1, 32'h101, 32'h0, 32'hFFFFAABB, 0, 1, 1, n);
    waitIdle(0);
    checkOutput("mis_reads", read_ops - r0, 32'd2);
`endif

    // Sub-word store: read-modify-write, ready low for three cycles.
    r0 = read_ops;
    w0 = write_ops;
    applyStimulus(0, 1, SIZE_BYTE, 0, 32'h103, 32'h12345677, 32'h0, 0, 2, 1, n);
    checkOutput("sb_ready_n1", {31'b0, cpu_bus.io_req_ready}, 32'd0);
    @(negedge clock);
    checkOutput("sb_ready_n2", {31'b0, cpu_bus.io_req_ready}, 32'd0);
    @(negedge clock);
    checkOutput("sb_ready_n3", {31'b0, cpu_bus.io_req_ready}, 32'd0);
    @(negedge clock);
    checkOutput("sb_ready_n4", {31'b0, cpu_bus.io_req_ready}, 32'd1);
    waitIdle(0);
    checkOutput("sb_mem_word", mem[64], 32'h7799AABB);
    checkOutput("sb_reads", read_ops - r0, 32'd1);
    checkOutput("sb_writes", write_ops - w0, 32'd1);

    // Word store: single write, then read back.
    r0 = read_ops;
    w0 = write_ops;
    applyStimulus(0, 1, SIZE_WORD, 0, 32'h200, 32'hDEADBEEF, 32'h0, 0, 1, 1, n);
    waitIdle(0);
    checkOutput("sw_reads", read_ops - r0, 32'd0);
    checkOutput("sw_writes", write_ops - w0, 32'd1);
    applyStimulus(0, 0, SIZE_WORD, 0, 32'h200, 32'h0, 32'hDEADBEEF, 0, 1, 1, n);
    waitIdle(0);

    // Reset while a stalled read is outstanding.
    stall_cycles = 3;
    applyStimulus(0, 0, SIZE_WORD, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0, n);
    checkOutput("abort_req_before", {31'b0, mem_bus.io_dmem_request_valid}, 32'd1);
    checkOutput("abort_addr_held", mem_bus.io_dmem_request_bits_address, 32'h100);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_req_after", {31'b0, mem_bus.io_dmem_request_valid}, 32'd0);
    checkOutput("abort_no_resp", {31'b0, cpu_bus.io_resp_valid}, 32'd0);
    checkOutput("abort_ready", {31'b0, cpu_bus.io_req_ready}, 32'd1);
    repeat (4) @(negedge clock);

    // Following load with a two-cycle memory stall completes normally.
    stall_cycles = 2;
    applyStimulus(0, 0, SIZE_WORD, 0, 32'h200, 32'h0, 32'hDEADBEEF, 0, 3, 1, n);
    waitIdle(0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
